// File: rtl/rom_ctrl.sv
// rom_ctrl: eight-entry constant lookup with one-hot address select.
// Each rising edge registers one read. Entry i holds 8'h11 * (i + 1).
// The read has a latency of one cycle.
// Optional feature macro: ROM_CTRL_ERR_EN adds the err output.
// The err output flags a read attempted with a non-one-hot address.
module rom_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] addr,
    output logic [7:0] data,
    output logic       valid
`ifdef ROM_CTRL_ERR_EN
    ,
    output logic       err
`endif
);

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    // True when exactly one address bit is set.
    function automatic logic is_one_hot(input logic [DEPTH-1:0] a);
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            ones = ones + {3'd0, a[i]};
        end
        return (ones == 4'd1);
    endfunction

    // Fixed ROM image. The address is assumed to be one-hot already.
    function automatic logic [DATA_W-1:0] rom_word(input logic [DEPTH-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a[i]) begin
                w = w | DATA_W'(8'h11 * (i + 1));
            end
        end
        return w;
    endfunction

    logic              addr_ok;
    logic [DATA_W-1:0] word_p0;
    logic              hit_p0;

    // Combinational decode of the current address into a ROM word and hit flag.
    always_comb begin
        addr_ok = is_one_hot(addr);
        hit_p0  = en && addr_ok;
        word_p0 = hit_p0 ? rom_word(addr) : '0;
    end

    // Output registers. Reset clears every output asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            data  <= word_p0;
            valid <= hit_p0;
        end
    end

`ifdef ROM_CTRL_ERR_EN
    // Error flag: an enabled read that carries a non-one-hot address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= en && !addr_ok;
        end
    end
`endif

endmodule

// File: tb/tb_rom_ctrl.sv
// tb_rom_ctrl: self-checking bench for rom_ctrl.
// Directed scenarios come first, followed by randomized reads.
// All reads are checked against a simple arithmetic model.
// Define ROM_CTRL_ERR_EN to also exercise the err output.
`timescale 1ns/1ps
module tb_rom_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
`ifdef ROM_CTRL_ERR_EN
    logic       err;
`endif

    int checks;
    int failures;

    rom_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .addr  (addr),
        .data  (data),
        .valid (valid)
`ifdef ROM_CTRL_ERR_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a valid read returns 0x11 * (index + 1), otherwise zero.
    function automatic logic [7:0] exp_data(input logic e, input logic [7:0] a);
        if (!e || $countones(a) != 1) return 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) return 8'(17 * (i + 1));
        end
        return 8'h00;
    endfunction

    function automatic logic exp_valid(input logic e, input logic [7:0] a);
        return e && ($countones(a) == 1);
    endfunction

    function automatic logic exp_err(input logic e, input logic [7:0] a);
        return e && ($countones(a) != 1);
    endfunction

    // Apply inputs, then sample 1 ns after the next rising edge.
    task automatic step(input logic e, input logic [7:0] a);
        en   = e;
        addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b1;
        addr = 8'h01;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (data !== 8'h00 || valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: data=%h valid=%b, want data=00 valid=0", data, valid);
            end
`ifdef ROM_CTRL_ERR_EN
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL reset_err: err=%b, want 0", err);
            end
`endif
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_disabled();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 8'h01);
            checks++;
            if (data !== 8'h00 || valid !== 1'b0) begin
                failures++;
                $display("FAIL disabled: data=%h valid=%b, want data=00 valid=0", data, valid);
            end
        end
    endtask

    task automatic test_walk();
        logic [7:0] a;
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            a    = 8'h01 << i;
            want = 8'(17 * (i + 1));
            step(1'b1, a);
            checks++;
            if (data !== want || valid !== 1'b1) begin
                failures++;
                $display("FAIL walk_%0d: addr=%h data=%h valid=%b, want data=%h valid=1", i, a, data, valid, want);
            end
`ifdef ROM_CTRL_ERR_EN
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL walk_err_%0d: err=%b, want 0", i, err);
            end
`endif
        end
    endtask

    task automatic test_invalid();
        logic [7:0] bad [4];
        bad[0] = 8'h00;
        bad[1] = 8'h03;
        bad[2] = 8'hFF;
        bad[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bad[i]);
            checks++;
            if (data !== 8'h00 || valid !== 1'b0) begin
                failures++;
                $display("FAIL invalid_%h: data=%h valid=%b, want data=00 valid=0", bad[i], data, valid);
            end
`ifdef ROM_CTRL_ERR_EN
            checks++;
            if (err !== 1'b1) begin
                failures++;
                $display("FAIL invalid_err_%h: err=%b, want 1", bad[i], err);
            end
`endif
        end
    endtask

    task automatic test_drop_en();
        step(1'b1, 8'h80);
        checks++;
        if (data !== 8'h88 || valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_en_pre: data=%h valid=%b, want data=88 valid=1", data, valid);
        end
        step(1'b0, 8'h80);
        checks++;
        if (data !== 8'h00 || valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_en: data=%h valid=%b, want data=00 valid=0", data, valid);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h10);
        checks++;
        if (data !== 8'h55 || valid !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: data=%h valid=%b, want data=55 valid=1", data, valid);
        end
`ifdef ROM_CTRL_ERR_EN
        step(1'b1, 8'h00);
        step(1'b1, 8'h10);
`endif
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (data !== 8'h00 || valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: data=%h valid=%b, want data=00 valid=0", data, valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data !== 8'h00 || valid !== 1'b0) begin
            failures++;
            $display("FAIL async_hold: data=%h valid=%b, want data=00 valid=0", data, valid);
        end
        rst = 1'b0;
        step(1'b1, 8'h04);
        checks++;
        if (data !== 8'h33 || valid !== 1'b1) begin
            failures++;
            $display("FAIL after_reset: data=%h valid=%b, want data=33 valid=1", data, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic       e;
        logic [7:0] a;
        for (int k = 0; k < 300; k++) begin
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) a = 8'h01 << $urandom_range(0, 7);
            else                           a = 8'($urandom);
            step(e, a);
            checks++;
            if (data !== exp_data(e, a) || valid !== exp_valid(e, a)) begin
                failures++;
                $display("FAIL random_%0d: en=%b addr=%h data=%h valid=%b, want data=%h valid=%b",
                         k, e, a, data, valid, exp_data(e, a), exp_valid(e, a));
            end
`ifdef ROM_CTRL_ERR_EN
            checks++;
            if (err !== exp_err(e, a)) begin
                failures++;
                $display("FAIL random_err_%0d: en=%b addr=%h err=%b, want %b", k, e, a, err, exp_err(e, a));
            end
`endif
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        addr     = 8'h00;
        test_reset();
        test_disabled();
        test_walk();
        test_invalid();
        test_drop_en();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
